// File: rtl/data_distributor.sv
// ============================================================================
// Module  : data_distributor
// Brief   : Deals a word stream round-robin into PE columns, hands off full rows.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_distributor #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COL    = 7
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  clr,
  input  logic [7:0]                            kernel_size,
  input  logic [2*DATA_WIDTH-1:0]               s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [NUM_COL-1:0][2*DATA_WIDTH-1:0]  pe_data,
  output logic [NUM_COL-1:0]                    pe_col_en,
  output logic                                  pe_valid,
  input  logic                                  pe_ready,
  output logic [15:0]                           row_cnt,
  output logic                                  err_ksize
);

  localparam int CW = $clog2(NUM_COL + 1);
  localparam int WW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                      r_state;
  logic [NUM_COL-1:0][WW-1:0]  r_fill;
  logic [CW-1:0]               r_ptr;
  logic [CW-1:0]               r_ks;

  logic [NUM_COL-1:0][WW-1:0]  w_fill_nxt;
  logic [NUM_COL-1:0][WW-1:0]  w_row_data;
  logic [NUM_COL-1:0]          w_row_en;
  logic [CW-1:0]               w_row_ks;
  logic [CW-1:0]               w_wr_idx;
  logic                        w_accept;
  logic                        w_last;
  logic                        w_free;
  logic                        w_xfer;

  assign err_ksize = (kernel_size == 8'd0) || (kernel_size > 8'(NUM_COL));

  always_comb begin
    s_ready = 1'b0;
    case (r_state)
      ST_IDLE: s_ready = !err_ksize;
      ST_FILL: s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
    s_ready = s_ready && rstn && !clr;
  end

  assign w_accept = s_valid && s_ready;
  // In IDLE the row size is still the live input; it is only latched on accept.
  assign w_row_ks = (r_state == ST_IDLE) ? kernel_size[CW-1:0] : r_ks;
  assign w_wr_idx = (r_state == ST_IDLE) ? '0 : r_ptr;
  assign w_last   = w_accept && (w_wr_idx == w_row_ks - CW'(1));
  assign w_free   = !pe_valid || pe_ready;
  assign w_xfer   = (w_last || (r_state == ST_HOLD)) && w_free;

  generate
    for (genvar i = 0; i < NUM_COL; i++) begin : g_col
      assign w_fill_nxt[i] = (w_accept && (w_wr_idx == CW'(i))) ? s_data : r_fill[i];
      assign w_row_en[i]   = (CW'(i) < w_row_ks);
      assign w_row_data[i] = w_row_en[i] ? w_fill_nxt[i] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_fill    <= '0;
      r_ptr     <= '0;
      r_ks      <= '0;
      pe_data   <= '0;
      pe_col_en <= '0;
      pe_valid  <= 1'b0;
      row_cnt   <= '0;
    end else if (clr) begin
      r_state   <= ST_IDLE;
      r_fill    <= '0;
      r_ptr     <= '0;
      r_ks      <= '0;
      pe_data   <= '0;
      pe_col_en <= '0;
      pe_valid  <= 1'b0;
      row_cnt   <= '0;
    end else begin
      r_fill <= w_fill_nxt;

      if (w_xfer) begin
        pe_data   <= w_row_data;
        pe_col_en <= w_row_en;
        pe_valid  <= 1'b1;
        row_cnt   <= row_cnt + 16'd1;
      end else if (pe_valid && pe_ready) begin
        pe_valid  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ks <= w_row_ks;
            if (w_last) begin
              r_state <= w_free ? ST_IDLE : ST_HOLD;
              r_ptr   <= '0;
            end else begin
              r_state <= ST_FILL;
              r_ptr   <= CW'(1);
            end
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            if (w_last) begin
              r_state <= w_free ? ST_IDLE : ST_HOLD;
              r_ptr   <= '0;
            end else begin
              r_ptr   <= r_ptr + CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (w_free) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_distributor.sv
// ============================================================================
// Module  : tb_data_distributor
// Brief   : Directed self-checking bench for data_distributor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_distributor;

  localparam int DW = 32;
  localparam int NC = 7;
  localparam int WW = 2 * DW;

  typedef logic [NC-1:0][WW-1:0] row_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            clr = 1'b0;
  logic [7:0]      kernel_size = 8'd3;
  logic [WW-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  row_t            pe_data;
  logic [NC-1:0]   pe_col_en;
  logic            pe_valid;
  logic            pe_ready = 1'b0;
  logic [15:0]     row_cnt;
  logic            err_ksize;

  int vec  = 0;
  int errs = 0;

  data_distributor #(.DATA_WIDTH(DW), .NUM_COL(NC)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .kernel_size(kernel_size),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pe_data(pe_data), .pe_col_en(pe_col_en), .pe_valid(pe_valid),
    .pe_ready(pe_ready), .row_cnt(row_cnt), .err_ksize(err_ksize)
  );

  always #5 clk = ~clk;

  // Row of n consecutive words starting at 'first', zero elsewhere.
  function automatic row_t mk_row(input int first, input int n);
    row_t r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = WW'(first + i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d);
    s_valid = v;
    s_data  = WW'(d);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vec++; if (s_ready !== 1'b0) begin errs++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    vec++; if (pe_valid !== 1'b0) begin errs++; $display("FAIL rst_pe_valid: got %b want 0", pe_valid); end
    vec++; if (row_cnt !== 16'd0) begin errs++; $display("FAIL rst_row_cnt: got %0d want 0", row_cnt); end
    vec++; if ({pe_col_en, pe_data} !== '0) begin errs++; $display("FAIL rst_pe_out: got en=%b data=%h want 0", pe_col_en, pe_data); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic e;
    kernel_size = 8'd3;
    pe_ready    = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, k);
      vec++; if (s_ready !== 1'b1) begin errs++; $display("FAIL t1_s_ready beat %0d: got %b want 1", k, s_ready); end
      tick();
      e = (k % 3 == 0);
      vec++; if (pe_valid !== e) begin errs++; $display("FAIL t1_pe_valid beat %0d: got %b want %b", k, pe_valid, e); end
      if (e) begin
        vec++; if (pe_data !== mk_row(k - 2, 3)) begin errs++; $display("FAIL t1_pe_data beat %0d: got %h want %h", k, pe_data, mk_row(k - 2, 3)); end
        vec++; if (pe_col_en !== 7'b0000111) begin errs++; $display("FAIL t1_col_en: got %b want 0000111", pe_col_en); end
      end
    end
    vec++; if (row_cnt !== 16'd2) begin errs++; $display("FAIL t1_row_cnt: got %0d want 2", row_cnt); end
    drive(1'b0, 0);
    tick();
    vec++; if (pe_valid !== 1'b0) begin errs++; $display("FAIL t1_drain: got %b want 0", pe_valid); end
    vec++; if (pe_data !== mk_row(4, 3)) begin errs++; $display("FAIL t1_data_kept: got %h want %h", pe_data, mk_row(4, 3)); end
  endtask

  task automatic test_hold();
    kernel_size = 8'd7;
    pe_ready    = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      drive(1'b1, 100 + k);
      vec++; if (s_ready !== 1'b1) begin errs++; $display("FAIL t2_s_ready beat %0d: got %b want 1", k, s_ready); end
      tick();
      if (k == 7 || k == 14) begin
        vec++; if ({pe_valid, pe_col_en} !== 8'hFF) begin errs++; $display("FAIL t2_row1 beat %0d: got v=%b en=%b want 1/1111111", k, pe_valid, pe_col_en); end
        vec++; if (pe_data !== mk_row(101, 7)) begin errs++; $display("FAIL t2_row1_data beat %0d: got %h want %h", k, pe_data, mk_row(101, 7)); end
      end
    end
    vec++; if (s_ready !== 1'b0) begin errs++; $display("FAIL t2_hold_s_ready: got %b want 0", s_ready); end
    drive(1'b0, 0);
    tick();
    tick();
    vec++; if ({pe_valid, s_ready, row_cnt} !== {1'b1, 1'b0, 16'd3}) begin errs++; $display("FAIL t2_hold_wait: got v=%b rdy=%b cnt=%0d want 1/0/3", pe_valid, s_ready, row_cnt); end
    vec++; if (pe_data !== mk_row(101, 7)) begin errs++; $display("FAIL t2_hold_data: got %h want %h", pe_data, mk_row(101, 7)); end
    pe_ready = 1'b1;
    tick();
    vec++; if ({pe_valid, s_ready, row_cnt} !== {1'b1, 1'b1, 16'd4}) begin errs++; $display("FAIL t2_release: got v=%b rdy=%b cnt=%0d want 1/1/4", pe_valid, s_ready, row_cnt); end
    vec++; if (pe_data !== mk_row(108, 7)) begin errs++; $display("FAIL t2_row2_data: got %h want %h", pe_data, mk_row(108, 7)); end
    tick();
    vec++; if (pe_valid !== 1'b0) begin errs++; $display("FAIL t2_drain: got %b want 0", pe_valid); end
  endtask

  task automatic test_ks1();
    kernel_size = 8'd1;
    pe_ready    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5 + k);
      tick();
      vec++; if ({pe_valid, pe_col_en, row_cnt} !== {1'b1, 7'b0000001, 16'(5 + k)}) begin errs++; $display("FAIL t3_row %0d: got v=%b en=%b cnt=%0d want 1/0000001/%0d", k, pe_valid, pe_col_en, row_cnt, 5 + k); end
      vec++; if (pe_data !== mk_row(5 + k, 1)) begin errs++; $display("FAIL t3_data %0d: got %h want %h", k, pe_data, mk_row(5 + k, 1)); end
    end
    drive(1'b0, 0);
    tick();
    vec++; if (pe_valid !== 1'b0) begin errs++; $display("FAIL t3_drain: got %b want 0", pe_valid); end
  endtask

  task automatic test_bad_ksize();
    logic [7:0] bad [3] = '{8'd0, 8'd9, 8'd8};
    for (int i = 0; i < 3; i++) begin
      kernel_size = bad[i];
      drive(1'b1, 99);
      vec++; if ({err_ksize, s_ready} !== 2'b10) begin errs++; $display("FAIL t4_err ks=%0d: got err=%b rdy=%b want 1/0", bad[i], err_ksize, s_ready); end
      tick();
      tick();
      vec++; if ({pe_valid, row_cnt} !== {1'b0, 16'd7}) begin errs++; $display("FAIL t4_no_row ks=%0d: got v=%b cnt=%0d want 0/7", bad[i], pe_valid, row_cnt); end
    end
    kernel_size = 8'd7;
    drive(1'b0, 0);
    vec++; if (err_ksize !== 1'b0) begin errs++; $display("FAIL t4_ks_max: got err=%b want 0", err_ksize); end
    kernel_size = 8'd2;
    drive(1'b1, 11);
    vec++; if ({err_ksize, s_ready} !== 2'b01) begin errs++; $display("FAIL t4_resume: got err=%b rdy=%b want 0/1", err_ksize, s_ready); end
    tick();
    drive(1'b1, 12);
    tick();
    vec++; if ({pe_valid, pe_col_en, row_cnt} !== {1'b1, 7'b0000011, 16'd8}) begin errs++; $display("FAIL t4_row: got v=%b en=%b cnt=%0d want 1/0000011/8", pe_valid, pe_col_en, row_cnt); end
    vec++; if (pe_data !== mk_row(11, 2)) begin errs++; $display("FAIL t4_data: got %h want %h", pe_data, mk_row(11, 2)); end
    drive(1'b0, 0);
    tick();
  endtask

  task automatic test_ks_change();
    kernel_size = 8'd4;
    drive(1'b1, 21); tick();
    drive(1'b1, 22); tick();
    kernel_size = 8'd2;
    drive(1'b1, 23);
    vec++; if (s_ready !== 1'b1) begin errs++; $display("FAIL t5_s_ready: got %b want 1", s_ready); end
    tick();
    vec++; if (pe_valid !== 1'b0) begin errs++; $display("FAIL t5_no_early_row: got %b want 0", pe_valid); end
    drive(1'b1, 24); tick();
    vec++; if ({pe_valid, pe_col_en, row_cnt} !== {1'b1, 7'b0001111, 16'd9}) begin errs++; $display("FAIL t5_row4: got v=%b en=%b cnt=%0d want 1/0001111/9", pe_valid, pe_col_en, row_cnt); end
    vec++; if (pe_data !== mk_row(21, 4)) begin errs++; $display("FAIL t5_data4: got %h want %h", pe_data, mk_row(21, 4)); end
    drive(1'b1, 25); tick();
    drive(1'b1, 26); tick();
    vec++; if ({pe_valid, pe_col_en, row_cnt} !== {1'b1, 7'b0000011, 16'd10}) begin errs++; $display("FAIL t5_row2: got v=%b en=%b cnt=%0d want 1/0000011/10", pe_valid, pe_col_en, row_cnt); end
    vec++; if (pe_data !== mk_row(25, 2)) begin errs++; $display("FAIL t5_data2: got %h want %h", pe_data, mk_row(25, 2)); end
    drive(1'b0, 0);
    tick();
  endtask

  task automatic test_clear_reset();
    kernel_size = 8'd3;
    pe_ready    = 1'b1;
    drive(1'b1, 31); tick();
    drive(1'b1, 32); tick();
    drive(1'b0, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vec++; if ({pe_valid, row_cnt} !== 17'd0 || pe_data !== '0) begin errs++; $display("FAIL t6_clr: got v=%b cnt=%0d data=%h want 0/0/0", pe_valid, row_cnt, pe_data); end
    for (int k = 33; k <= 35; k++) begin
      drive(1'b1, k);
      tick();
    end
    vec++; if ({pe_valid, row_cnt} !== {1'b1, 16'd1}) begin errs++; $display("FAIL t6_after_clr: got v=%b cnt=%0d want 1/1", pe_valid, row_cnt); end
    vec++; if (pe_data !== mk_row(33, 3)) begin errs++; $display("FAIL t6_after_clr_data: got %h want %h", pe_data, mk_row(33, 3)); end
    drive(1'b0, 0);
    tick();
    pe_ready    = 1'b0;
    kernel_size = 8'd2;
    for (int k = 41; k <= 44; k++) begin
      drive(1'b1, k);
      tick();
    end
    drive(1'b0, 0);
    vec++; if ({s_ready, pe_valid, row_cnt} !== {1'b0, 1'b1, 16'd2}) begin errs++; $display("FAIL t6_hold: got rdy=%b v=%b cnt=%0d want 0/1/2", s_ready, pe_valid, row_cnt); end
    rstn = 1'b0;
    #1;
    vec++; if ({s_ready, pe_valid, row_cnt} !== 18'd0 || pe_data !== '0) begin errs++; $display("FAIL t6_rst: got rdy=%b v=%b cnt=%0d data=%h want 0", s_ready, pe_valid, row_cnt, pe_data); end
    tick();
    rstn     = 1'b1;
    pe_ready = 1'b1;
    tick();
    tick();
    vec++; if ({pe_valid, row_cnt} !== 17'd0) begin errs++; $display("FAIL t6_no_ghost: got v=%b cnt=%0d want 0/0", pe_valid, row_cnt); end
    drive(1'b1, 51); tick();
    drive(1'b1, 52); tick();
    vec++; if ({pe_valid, row_cnt} !== {1'b1, 16'd1}) begin errs++; $display("FAIL t6_resume: got v=%b cnt=%0d want 1/1", pe_valid, row_cnt); end
    vec++; if (pe_data !== mk_row(51, 2)) begin errs++; $display("FAIL t6_resume_data: got %h want %h", pe_data, mk_row(51, 2)); end
    drive(1'b0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_ks1();
    test_bad_ksize();
    test_ks_change();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
